// File: rtl/xc_malu_ctrl.sv
// Issue/writeback sequencer for the multi-cycle arithmetic unit (MALU).
// Latency: accept -> BUSY next cycle; result writeback starts the cycle after malu_ready.
// Backpressure: in_ready only when idle and not killed; writeback beats hold until wb_ready.
module xc_malu_ctrl #(
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [2:0]  in_pw,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_rs3,
  input  logic [4:0]  in_rd,
  input  logic        in_wide,
  input  logic        in_hi,
  input  logic        kill,
  output logic        malu_valid,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic        malu_flush,
  output logic [31:0] malu_flush_data,
  input  logic [63:0] malu_result,
  input  logic        malu_ready,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'h0000_0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY  = 3'd1,
    WB_LO = 3'd2,
    WB_HI = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t      state;
  logic [13:0] uop_q;
  logic [4:0]  pw_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] rs3_q;
  logic [4:0]  rd_q;
  logic        wide_q;
  logic        hi_q;
  logic [63:0] result_q;
  logic [31:0] lfsr_q;
  logic        err_q;

  logic        accept;
  logic        op_legal;
  logic [4:0]  pw_onehot;
  logic [31:0] lfsr_next;

  assign in_ready  = resetn && (state == IDLE) && !kill;
  assign accept    = in_valid && in_ready;
  assign op_legal  = (in_op < 4'd14);
  assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

  // Pack width to one-hot {pw_2,pw_4,pw_8,pw_16,pw_32}; unused encodings fall back to 32-bit.
  always_comb begin
    pw_onehot = 5'b00001;
    case (in_pw)
      3'd1:    pw_onehot = 5'b00010;
      3'd2:    pw_onehot = 5'b00100;
      3'd3:    pw_onehot = 5'b01000;
      3'd4:    pw_onehot = 5'b10000;
      default: pw_onehot = 5'b00001;
    endcase
  end

  // Control FSM plus all captured operand, result, LFSR and error state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      uop_q    <= '0;
      pw_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      rd_q     <= '0;
      wide_q   <= 1'b0;
      hi_q     <= 1'b0;
      result_q <= '0;
      lfsr_q   <= SEED;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_legal) begin
              uop_q  <= 14'd1 << in_op;
              pw_q   <= pw_onehot;
              rs1_q  <= in_rs1;
              rs2_q  <= in_rs2;
              rs3_q  <= in_rs3;
              rd_q   <= in_rd;
              wide_q <= in_wide;
              hi_q   <= in_hi;
              state  <= BUSY;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          // kill beats a same-cycle malu_ready; the result is dropped.
          if (kill) begin
            state <= FLUSH;
          end else if (malu_ready) begin
            result_q <= malu_result;
            state    <= WB_LO;
          end
        end
        WB_LO: begin
          if (kill) begin
            state <= FLUSH;
          end else if (wb_ready) begin
            state <= wide_q ? WB_HI : FLUSH;
          end
        end
        WB_HI: begin
          if (kill || wb_ready) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          lfsr_q <= lfsr_next;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MALU-facing outputs are decoded from registered state; zero outside BUSY.
  always_comb begin
    malu_valid = (state == BUSY) && !kill;
    malu_uop   = '0;
    malu_pw    = '0;
    malu_rs1   = '0;
    malu_rs2   = '0;
    malu_rs3   = '0;
    if (state == BUSY) begin
      malu_uop = uop_q;
      malu_pw  = pw_q;
      malu_rs1 = rs1_q;
      malu_rs2 = rs2_q;
      malu_rs3 = rs3_q;
    end
  end

  // Scrub pulse carries the current LFSR value; it advances as the pulse retires.
  always_comb begin
    malu_flush      = (state == FLUSH);
    malu_flush_data = (state == FLUSH) ? lfsr_q : 32'd0;
  end

  // Writeback beats: low beat (or selected half for narrow ops), then high beat to rd+1.
  always_comb begin
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    case (state)
      WB_LO: begin
        wb_valid = !kill;
        wb_rd    = rd_q;
        wb_data  = (wide_q || !hi_q) ? result_q[31:0] : result_q[63:32];
      end
      WB_HI: begin
        wb_valid = !kill;
        wb_rd    = rd_q + 5'd1;
        wb_data  = result_q[63:32];
      end
      default: begin
        wb_valid = 1'b0;
      end
    endcase
  end

  assign err = err_q;

endmodule
